// File: rtl/pipe_stage_reg_if.sv
// Ready/valid channel between pipeline stages: datapath payload plus control payload.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 16
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with a two-entry skid buffer, synchronous flush
// and a saturating stall counter. Every output is driven straight from a register.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_stage_reg_if.slave  up,
    pipe_stage_reg_if.master dn,
    output logic             skid_full,
    output logic [CNT_W-1:0] stall_cnt
);

    logic              main_v;
    logic [DATA_W-1:0] main_d;
    logic [CTRL_W-1:0] main_c;
    logic              skid_v;
    logic [DATA_W-1:0] skid_d;
    logic [CTRL_W-1:0] skid_c;

    logic acc;
    logic pop;
    logic main_free;
    logic stalled;

    always_comb begin
        acc       = up.valid && !skid_v;
        pop       = main_v && dn.ready;
        main_free = !main_v || pop;
        stalled   = main_v && !dn.ready;
    end

    // in_ready depends only on skid occupancy, so no path from out_ready reaches it.
    assign up.ready  = !skid_v;
    assign dn.valid  = main_v;
    assign dn.data   = main_d;
    assign dn.ctrl   = main_c;
    assign skid_full = skid_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v <= 1'b0;
            main_d <= '0;
            main_c <= '0;
            skid_v <= 1'b0;
            skid_d <= '0;
            skid_c <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            main_d <= '0;
            main_c <= '0;
            skid_v <= 1'b0;
            skid_d <= '0;
            skid_c <= '0;
        end else if (main_free) begin
            if (skid_v) begin
                // Skid entry is always older than anything still upstream.
                main_v <= 1'b1;
                main_d <= skid_d;
                main_c <= skid_c;
                skid_v <= 1'b0;
            end else if (acc) begin
                main_v <= 1'b1;
                main_d <= up.data;
                main_c <= up.ctrl;
            end else begin
                main_v <= 1'b0;
                main_d <= '0;
                main_c <= '0;
            end
        end else if (acc) begin
            skid_v <= 1'b1;
            skid_d <= up.data;
            skid_c <= up.ctrl;
        end
    end

    // Only reset clears the counter; flush leaves the debug history intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stalled && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a queue model.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        skid_full;
    logic [15:0] stall_cnt;
    logic        sat_skid;
    logic [3:0]  sat_cnt;

    int n_pass = 0;
    int n_chk  = 0;

    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(16)) up ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(16)) dn ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(16)) sat_up ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(16)) sat_dn ();

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .up        (up),
        .dn        (dn),
        .skid_full (skid_full),
        .stall_cnt (stall_cnt)
    );

    // Narrow-counter twin fed the same traffic to exercise saturation.
    assign sat_up.valid = up.valid;
    assign sat_up.data  = up.data;
    assign sat_up.ctrl  = up.ctrl;
    assign sat_dn.ready = dn.ready;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .CNT_W(4)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .up        (sat_up),
        .dn        (sat_dn),
        .skid_full (sat_skid),
        .stall_cnt (sat_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Model: FIFO of held instructions (oldest first, at most two) and stall counts.
    logic [31:0] q_d[$];
    logic [15:0] q_c[$];
    int          m_cnt = 0;
    int          m_sat = 0;
    int          m_n;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_d.delete();
            q_c.delete();
            m_cnt = 0;
            m_sat = 0;
        end else begin
            m_n = q_d.size();
            if (m_n > 0 && !dn.ready) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_sat < 15) m_sat++;
            end
            if (flush) begin
                q_d.delete();
                q_c.delete();
            end else begin
                if (m_n > 0 && dn.ready) begin
                    void'(q_d.pop_front());
                    void'(q_c.pop_front());
                end
                if (up.valid && m_n < 2) begin
                    q_d.push_back(up.data);
                    q_c.push_back(up.ctrl);
                end
            end
        end
    end

    int c_n;

    always @(negedge clk) begin
        c_n = q_d.size();
        chk("in_ready", {63'd0, up.ready}, {63'd0, c_n < 2});
        chk("out_valid", {63'd0, dn.valid}, {63'd0, c_n > 0});
        chk("out_data", {32'd0, dn.data}, {32'd0, (c_n > 0) ? q_d[0] : 32'd0});
        chk("out_ctrl", {48'd0, dn.ctrl}, {48'd0, (c_n > 0) ? q_c[0] : 16'd0});
        chk("skid_full", {63'd0, skid_full}, {63'd0, c_n == 2});
        chk("stall_cnt", {48'd0, stall_cnt}, 64'(m_cnt));
        chk("sat_cnt", {60'd0, sat_cnt}, 64'(m_sat));
        chk("sat_data", {32'd0, sat_dn.data}, {32'd0, (c_n > 0) ? q_d[0] : 32'd0});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        up.valid = 1'b1;
        up.data  = 32'hDEAD_BEEF;
        up.ctrl  = 16'hFFFF;
        dn.ready = 1'b1;
        rst      = 1'b1;
        step();
        step();
        chk("rst_valid", {63'd0, dn.valid}, 64'd0);
        chk("rst_data", {32'd0, dn.data}, 64'd0);
        rst      = 1'b0;
        up.valid = 1'b0;
        repeat (3) step();
        chk("idle_ready", {63'd0, up.ready}, 64'd1);
        chk("idle_cnt", {48'd0, stall_cnt}, 64'd0);

        // Streaming 1..8 back to back
        for (int i = 1; i <= 8; i++) begin
            up.valid = 1'b1;
            up.data  = 32'(i);
            up.ctrl  = 16'(i + 100);
            step();
            chk("stream_data", {32'd0, dn.data}, 64'(i));
            chk("stream_skid", {63'd0, skid_full}, 64'd0);
        end
        up.valid = 1'b0;
        step();
        chk("stream_end", {63'd0, dn.valid}, 64'd0);

        // Stall and skid: A in main, B into skid, C held upstream
        up.valid = 1'b1;
        up.data  = 32'hA;
        up.ctrl  = 16'h1;
        step();
        dn.ready = 1'b0;
        up.data  = 32'hB;
        step();
        chk("skid_fill", {63'd0, skid_full}, 64'd1);
        chk("skid_ready", {63'd0, up.ready}, 64'd0);
        up.data = 32'hC;
        repeat (4) step();
        chk("stall5", {48'd0, stall_cnt}, 64'd5);
        chk("order_a", {32'd0, dn.data}, 64'hA);
        dn.ready = 1'b1;
        step();
        chk("order_b", {32'd0, dn.data}, 64'hB);
        chk("drain_ready", {63'd0, up.ready}, 64'd1);
        step();
        chk("order_c", {32'd0, dn.data}, 64'hC);
        up.valid = 1'b0;
        step();
        chk("order_end", {63'd0, dn.valid}, 64'd0);

        // Flush with both entries full and a simultaneous pop
        up.valid = 1'b1;
        up.data  = 32'hA;
        dn.ready = 1'b0;
        step();
        up.data = 32'hB;
        step();
        flush    = 1'b1;
        up.data  = 32'hD;
        dn.ready = 1'b1;
        step();
        flush    = 1'b0;
        up.valid = 1'b0;
        chk("flush_valid", {63'd0, dn.valid}, 64'd0);
        chk("flush_ctrl", {48'd0, dn.ctrl}, 64'd0);
        chk("flush_ready", {63'd0, up.ready}, 64'd1);
        chk("flush_cnt", {48'd0, stall_cnt}, 64'd6);
        step();
        chk("flush_drop", {63'd0, dn.valid}, 64'd0);

        // Saturation: 20 stalled cycles, both entries full at the end
        up.valid = 1'b1;
        up.data  = 32'hA;
        dn.ready = 1'b0;
        step();
        up.data = 32'hB;
        repeat (20) step();
        chk("sat15", {60'd0, sat_cnt}, 64'd15);
        chk("cnt26", {48'd0, stall_cnt}, 64'd26);
        chk("sat_full", {63'd0, skid_full}, 64'd1);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, dn.valid}, 64'd0);
        chk("arst_skid", {63'd0, skid_full}, 64'd0);
        chk("arst_cnt", {48'd0, stall_cnt}, 64'd0);
        chk("arst_ready", {63'd0, up.ready}, 64'd1);
        step();
        rst      = 1'b0;
        up.valid = 1'b0;
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            up.valid = ($urandom % 4) != 0;
            up.data  = $urandom;
            up.ctrl  = 16'($urandom);
            dn.ready = ($urandom % 10) < 7;
            flush    = ($urandom % 32) == 0;
            rst      = rst ? 1'b0 : (($urandom % 400) == 0);
            step();
        end
        rst      = 1'b0;
        flush    = 1'b0;
        up.valid = 1'b0;
        dn.ready = 1'b1;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register for the inter-stage boundaries of the pipelined MIPS CPU (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It replaces the fixed-field, stall-only stage registers with a generic ready/valid stage. A two-entry skid buffer gives full throughput with a registered `in_ready`. A synchronous flush inserts bubbles, and a saturating stall counter supports performance debug. Control fields are zeroed in every bubble, so an empty stage never asserts a write enable downstream.

## Interface
- DATA_W, 32, width of the datapath payload (pc4, operands, immediates, ...), concatenated by the instantiating stage
- CTRL_W, 16, width of the control payload (write enables, mux selects, aluc, ...); forced to zero in bubbles
- CNT_W, 16, width of the stall-cycle counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous squash of both entries (branch / exception redirect)
- in_valid  in  1  upstream stage presents a valid instruction
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_data  in  DATA_W  upstream datapath payload
- in_ctrl  in  CTRL_W  upstream control payload
- out_valid  out  1  main entry holds a valid instruction
- out_ready  in  1  downstream stage consumes this cycle (deasserted = hazard stall)
- out_data  out  DATA_W  main-entry datapath payload
- out_ctrl  out  CTRL_W  main-entry control payload
- skid_full  out  1  skid entry occupied (debug)
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating

## Operation
- State: main entry (main_v, main_d, main_c) and skid entry (skid_v, skid_d, skid_c). out_* is driven directly from the main entry. skid_full is driven from skid_v.
- Definitions: acc = in_valid && in_ready; pop = out_valid && out_ready.
- Priority per clock edge: rst > flush > normal update.
- Flush: main_v and skid_v are cleared, and all data and ctrl registers are cleared to 0.
  - Any acc in the same cycle is discarded.
  - stall_cnt is not affected.
- Normal update, main-entry source:
  - main empty or pop, skid_v=1: main loads the skid entry and skid_v clears.
  - main empty or pop, skid_v=0, acc: main loads the input.
  - main empty or pop, skid_v=0, no acc: main_v is cleared, and main_d and main_c are zeroed (bubble).
  - main full and no pop: main holds.
- Normal update, skid-entry fill:
  - acc while main is full, no pop, and skid is empty: the input loads into skid.
  - No other case writes skid. acc with skid_v=1 cannot occur because in_ready=0.
- Ordering: the skid entry is always older than any new input. Instructions leave in the same order they were accepted.
- Bubble invariant: out_valid=0 implies out_data=0 and out_ctrl=0.
- Stall counter: increments by 1 each cycle that out_valid && !out_ready, and saturates at 2^CNT_W-1. Only rst clears it.
- Occupancy is 0, 1 or 2 entries. skid_v=1 implies main_v=1.

## Timing
- Reset values:
  - in_ready=1.
  - out_valid=0, out_data=0, out_ctrl=0.
  - skid_full=0, stall_cnt=0.
- Latency: an instruction accepted at edge N appears on out_* after edge N when the stage was empty. This is one-cycle latency, identical to the previous stage registers.
- Throughput: one instruction per cycle while out_ready=1.
- in_ready is a pure register output with no combinational path from out_ready. It deasserts the cycle after the skid fills and reasserts the cycle after the skid drains.
- No combinational path from any input to any output.
- Simultaneous flush and pop: the popped instruction is consumed downstream, and the stage is empty after the edge.
- Reset asserted mid-operation: all outputs take their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset and bubble: assert rst with in_valid=1 and in_data=32'hDEAD_BEEF, then release it and hold in_valid=0. Required: out_valid=0, out_data=0, out_ctrl=0, in_ready=1 and stall_cnt=0 on every cycle.
- Streaming: apply values 1..8 back-to-back with out_ready=1. Required: out_data equals 1..8 on consecutive cycles, each one cycle after its accept, and skid_full stays 0.
- Stall and skid: load A, then drop out_ready for 5 cycles while presenting B and C. Required:
  - B is captured in skid.
  - in_ready=0 from the next cycle, so C is held upstream.
  - stall_cnt=5.
  - After out_ready returns, the output order is A, B, C with no loss or duplication.
- Flush: with both entries full (A, B), pulse flush for 1 cycle while in_valid=1 with D. Required: the next cycle shows out_valid=0, out_ctrl=0 and in_ready=1, D is dropped, and stall_cnt is unchanged.
- Counter saturation: with CNT_W=4, hold a valid entry with out_ready=0 for 20 cycles. Required: stall_cnt stops at 15.
- Async reset mid-stall: with both entries full, assert rst between clock edges. Required: out_valid=0 and skid_full=0 before the next clk edge.
